// File: rtl/bitscan_encoder.sv
// bitscan_encoder: accepts a request vector and streams the index of each set bit, one per output handshake.
// Optional macro ZERO_BEAT_EN: an accepted all-zero vector produces one beat flagged by out_zero.
module bitscan_encoder #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
`ifdef ZERO_BEAT_EN
  ,
  output logic             out_zero
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, ZBEAT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [IDX_W-1:0] scan_idx;
  logic             single;

  // Priority encoder over pending; the last match in loop order wins.
  always_comb begin
    scan_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending[i]) scan_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (pending[i]) scan_idx = IDX_W'(i);
    end
  end

  assign single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  // Outputs depend only on registered state, so in_vec never reaches them combinationally.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    out_valid    = (state != IDLE);
    out_idx      = '0;
    out_last     = 1'b0;
`ifdef ZERO_BEAT_EN
    out_zero     = (state == ZBEAT);
`endif
    case (state)
      SCAN: begin
        out_idx  = scan_idx;
        out_last = single;
      end
      ZBEAT:   out_last = 1'b1;
      default: ;
    endcase

    in_ready = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));

    if (out_valid && out_ready) begin
      pending_next = pending & ~(WIDTH'(1) << scan_idx);
      if (out_last) state_next = IDLE;
    end

    // A vector accepted on the final beat overrides the return to IDLE.
    if (in_valid && in_ready) begin
      if (in_vec != '0) begin
        pending_next = in_vec;
        state_next   = SCAN;
      end else begin
`ifdef ZERO_BEAT_EN
        state_next   = ZBEAT;
`else
        state_next   = IDLE;
`endif
      end
    end
  end

endmodule
